// File: rtl/mux_pkg.sv
// Shared types and default sizing for the scan controller, the ternary mux and their benches.
package mux_pkg;

  localparam int DEF_WIDTH_IN  = 2;
  localparam int DEF_WIDTH_OP  = 4;
  localparam int DEF_WIDTH_BUS = 3;
  localparam int DEF_DWELL_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Downstream valid/ready channel carrying one captured mux option and its select index.
interface mux_scan_ctrl_if
  import mux_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_BUS = DEF_WIDTH_BUS
);
  logic [WIDTH_BUS-1:0] out_data;
  logic [WIDTH_IN-1:0]  out_idx;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_idx, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_idx, input  out_valid, output out_ready);
endinterface

// File: rtl/mux_dwell_cnt.sv
// Loadable down-counter timing the settle interval at each select value.
module mux_dwell_cnt
  import mux_pkg::*;
#(
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the controller never asks for both.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                      cnt_d = load_val;
    else if (en && cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_ternar_module.sv
// Parameterised bus mux: out follows opt[in]; select codes beyond WIDTH_OP-1 give zero.
module mux_ternar_module
  import mux_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_OP  = DEF_WIDTH_OP,
  parameter int WIDTH_BUS = DEF_WIDTH_BUS
) (
  input  logic [WIDTH_IN-1:0]  in,
  input  logic [WIDTH_BUS-1:0] opt [WIDTH_OP],
  output logic [WIDTH_BUS-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < WIDTH_OP; i++) begin
      if (in == WIDTH_IN'(i)) out = opt[i];
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks the mux select through every option, settles for a latched dwell at each,
// then offers the captured value downstream with its index.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_OP  = DEF_WIDTH_OP,
  parameter int WIDTH_BUS = DEF_WIDTH_BUS,
  parameter int DWELL_W   = DEF_DWELL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [WIDTH_IN-1:0]  sel,
  input  logic [WIDTH_BUS-1:0] mux_data,
  mux_scan_ctrl_if.master      out_if,
  output logic                 busy,
  output logic                 done
);

  localparam logic [WIDTH_IN-1:0] LAST_SEL = WIDTH_IN'(WIDTH_OP - 1);

  state_e               state_q, state_d;
  logic [WIDTH_IN-1:0]  sel_q, sel_d;
  logic [WIDTH_BUS-1:0] out_data_q, out_data_d;
  logic [WIDTH_IN-1:0]  out_idx_q, out_idx_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;

  logic                 cnt_load, cnt_en, cnt_zero;
  logic [DWELL_W-1:0]   cnt_load_val;

  mux_dwell_cnt #(.DWELL_W(DWELL_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    dwell_d      = dwell_q;
    cnt_load     = 1'b0;
    cnt_load_val = dwell_q;
    cnt_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d      = SETTLE;
          busy_d       = 1'b1;
          dwell_d      = dwell;
          cnt_load     = 1'b1;
          cnt_load_val = dwell;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          out_data_d  = mux_data;
          out_idx_d   = sel_q;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      OUTPUT: begin
        // Select and captured data stay frozen until the consumer takes them.
        if (out_if.out_ready) begin
          out_valid_d = 1'b0;
          if (sel_q == LAST_SEL) begin
            state_d = IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            sel_d    = sel_q + 1'b1;
            cnt_load = 1'b1;
            state_d  = SETTLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dwell_q     <= dwell_d;
    end
  end

  assign sel              = sel_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: scan controllers (4- and 3-option) driving the ternary mux.
module tb_mux_scan_ctrl;
  import mux_pkg::*;

  localparam int WI = 2;
  localparam int WB = 3;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, start3;
  logic [DW-1:0] dwell, dwell3;
  logic [WI-1:0] sel, sel3;
  logic [WB-1:0] mux_data, mux_data3;
  logic          busy, busy3, done, done3;
  logic [WB-1:0] opt4 [4];
  logic [WB-1:0] opt3 [3];

  assign opt4[0] = 3'b110;
  assign opt4[1] = 3'b100;
  assign opt4[2] = 3'b101;
  assign opt4[3] = 3'b011;
  assign opt3[0] = 3'b110;
  assign opt3[1] = 3'b100;
  assign opt3[2] = 3'b101;

  mux_scan_ctrl_if #(.WIDTH_IN(WI), .WIDTH_BUS(WB)) bus  ();
  mux_scan_ctrl_if #(.WIDTH_IN(WI), .WIDTH_BUS(WB)) bus3 ();

  mux_scan_ctrl #(.WIDTH_IN(WI), .WIDTH_OP(4), .WIDTH_BUS(WB), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dwell(dwell), .sel(sel),
    .mux_data(mux_data), .out_if(bus), .busy(busy), .done(done));
  mux_ternar_module #(.WIDTH_IN(WI), .WIDTH_OP(4), .WIDTH_BUS(WB)) mux4 (
    .in(sel), .opt(opt4), .out(mux_data));

  mux_scan_ctrl #(.WIDTH_IN(WI), .WIDTH_OP(3), .WIDTH_BUS(WB), .DWELL_W(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .dwell(dwell3), .sel(sel3),
    .mux_data(mux_data3), .out_if(bus3), .busy(busy3), .done(done3));
  mux_ternar_module #(.WIDTH_IN(WI), .WIDTH_OP(3), .WIDTH_BUS(WB)) mux3 (
    .in(sel3), .opt(opt3), .out(mux_data3));

  typedef struct packed {
    logic [WI-1:0] idx;
    logic [WB-1:0] data;
  } exp_t;

  // Hand-computed option values in scan order.
  logic [WB-1:0] exp_tab [4] = '{3'b110, 3'b100, 3'b101, 3'b011};

  exp_t q4[$];
  exp_t q3[$];
  int   hs_cyc[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done3_cnt = 0;
  int   done_cyc = 0;
  int   hs3_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every accepted transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.out_valid && bus.out_ready) begin
        if (q4.size() == 0) chk("unexpected_hs4", 1, 0);
        else begin
          e = q4.pop_front();
          chk("idx4", 32'(bus.out_idx), 32'(e.idx));
          chk("data4", 32'(bus.out_data), 32'(e.data));
          chk("sel4", 32'(sel), 32'(e.idx));
          hs_cyc.push_back(cyc);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_with_done", 32'(busy), 0);
      end
      if (bus3.out_valid && bus3.out_ready) begin
        if (q3.size() == 0) chk("unexpected_hs3", 1, 0);
        else begin
          e = q3.pop_front();
          chk("idx3", 32'(bus3.out_idx), 32'(e.idx));
          chk("data3", 32'(bus3.out_data), 32'(e.data));
          hs3_cnt++;
        end
      end
      if (busy3) chk("sel3_range", 32'(int'(sel3) <= 2), 1);
      if (done3) done3_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.idx  = WI'(i);
      e.data = exp_tab[i];
      q4.push_back(e);
    end
  endtask

  task automatic do_start(input logic [DW-1:0] d);
    dwell = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk(name, 0, 1);
  endtask

  task automatic wait_done(input string name, input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      tick();
      n++;
    end
    tick();
    chk(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic handshake_once();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; dwell = '0; dwell3 = '0;
    bus.out_ready = 1'b0; bus3.out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_idx", 32'(bus.out_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    // dwell=0, ready always high
    bus.out_ready = 1'b1;
    push4(); hs_cyc.delete(); d0 = done_cnt;
    do_start(4'd0);
    n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    chk("latency_dwell0", 32'(n), 1);
    wait_done("done_t1", d0 + 1);
    chk("hs_count_t1", 32'(hs_cyc.size()), 4);
    if (hs_cyc.size() == 4) chk("done_after_last_hs", 32'(done_cyc - hs_cyc[3]), 1);
    chk("q_empty_t1", 32'(q4.size()), 0);

    // dwell=3: 4 SETTLE + 1 OUTPUT per option
    push4(); hs_cyc.delete(); d0 = done_cnt;
    do_start(4'd3);
    n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    chk("latency_dwell3", 32'(n), 4);
    wait_done("done_t2", d0 + 1);
    chk("hs_count_t2", 32'(hs_cyc.size()), 4);
    if (hs_cyc.size() == 4)
      for (int i = 0; i < 3; i++) chk("gap_dwell3", 32'(hs_cyc[i+1] - hs_cyc[i]), 5);

    // backpressure held for 5 cycles at idx 1
    bus.out_ready = 1'b0;
    push4(); d0 = done_cnt;
    do_start(4'd1);
    for (int i = 0; i < 4; i++) begin
      wait_valid("bp_valid_timeout");
      if (i == 1) begin
        for (int k = 0; k < 5; k++) begin
          chk("bp_hold_valid", 32'(bus.out_valid), 1);
          chk("bp_hold_data", 32'(bus.out_data), 32'(3'b100));
          chk("bp_hold_idx", 32'(bus.out_idx), 1);
          chk("bp_hold_sel", 32'(sel), 1);
          tick();
        end
      end
      handshake_once();
    end
    wait_done("done_t3", d0 + 1);
    chk("q_empty_t3", 32'(q4.size()), 0);

    // start re-pulsed and dwell changed mid-scan
    bus.out_ready = 1'b1;
    push4(); hs_cyc.delete(); d0 = done_cnt;
    do_start(4'd2);
    n = 0;
    while (!(sel == 2'd2 && !bus.out_valid) && n < 100) begin tick(); n++; end
    chk("reach_settle_idx2", 32'(busy && sel == 2'd2 && !bus.out_valid), 1);
    dwell = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("done_t4", d0 + 1);
    chk("hs_count_t4", 32'(hs_cyc.size()), 4);
    if (hs_cyc.size() == 4)
      for (int i = 0; i < 3; i++) chk("gap_dwell2", 32'(hs_cyc[i+1] - hs_cyc[i]), 4);
    repeat (10) tick();
    chk("no_rescan_done", 32'(done_cnt), 32'(d0 + 1));
    chk("no_rescan_busy", 32'(busy), 0);

    // reset while presenting idx 2
    bus.out_ready = 1'b0;
    push4(); d0 = done_cnt;
    do_start(4'd0);
    for (int i = 0; i < 2; i++) begin
      wait_valid("rst_pre_valid_timeout");
      handshake_once();
    end
    wait_valid("rst_idx2_timeout");
    chk("pre_rst_idx", 32'(bus.out_idx), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_pending", 32'(q4.size()), 2);
    q4.delete();
    repeat (5) tick();
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    chk("midrst_still_idle", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    push4(); hs_cyc.delete();
    do_start(4'd0);
    wait_done("done_after_rst", d0 + 1);
    chk("hs_count_after_rst", 32'(hs_cyc.size()), 4);

    // three-option controller
    begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
        e.idx = WI'(i);
        e.data = exp_tab[i];
        q3.push_back(e);
      end
    end
    bus3.out_ready = 1'b1;
    dwell3 = 4'd1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    while (done3_cnt < 1 && n < 100) begin tick(); n++; end
    tick();
    chk("done3", 32'(done3_cnt), 1);
    chk("hs3_count", 32'(hs3_cnt), 3);
    chk("q3_empty", 32'(q3.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that sits directly upstream of the parameterised ternary bus mux and drives its select input. On each start it walks the select through all WIDTH_OP options and waits a programmable settle (dwell) time at each one. It then captures the mux output and hands it downstream over a valid/ready handshake, tagged with its index.

Parameters:
WIDTH_IN, 2, select width; must satisfy WIDTH_OP <= 2**WIDTH_IN
WIDTH_OP, 4, number of mux options scanned per start; minimum 1
WIDTH_BUS, 3, mux data bus width
DWELL_W, 4, width of the dwell (settle) count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-low
start  in  1  begin a scan; sampled only in IDLE
dwell  in  DWELL_W  settle cycles per option; latched when start is accepted
sel  out  WIDTH_IN  select to the mux (its `in` port)
mux_data  in  WIDTH_BUS  mux output (its `out` port); combinational from sel
out_data  out  WIDTH_BUS  captured option value
out_idx  out  WIDTH_IN  select value out_data was captured at
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  downstream accepts
busy  out  1  high in SETTLE and OUTPUT
done  out  1  one-cycle pulse after the last option is accepted

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n=0 at an edge): state IDLE, sel=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0, dwell latch=0, counter=0.
- States: IDLE, SETTLE, OUTPUT.
- IDLE, start=1 at edge: go to SETTLE, sel=0, latch dwell, counter=dwell.
- IDLE, start=0: stay; sel held at 0.
- SETTLE, counter!=0 at edge: counter decrements.
- SETTLE, counter==0 at edge: out_data<=mux_data, out_idx<=sel, out_valid<=1, go to OUTPUT.
  - Latency: out_valid is visible dwell+1 edges after the start edge.
  - dwell=0 captures on the first SETTLE edge.
- OUTPUT: out_valid, out_data, out_idx and sel are held stable until an edge with out_ready=1 (handshake). On handshake, out_valid<=0 and:
  - if sel==WIDTH_OP-1: go to IDLE, sel<=0, done<=1 for exactly one cycle;
  - else: sel<=sel+1, counter<=latched dwell, go to SETTLE.
- busy=1 exactly in SETTLE/OUTPUT (registered with state). done and busy=0 appear in the same cycle.
- start is ignored while busy. The dwell input is ignored after it is latched; changing it mid-scan has no effect.
- out_ready while out_valid=0 is ignored.
- sel never exceeds WIDTH_OP-1 (no wrap through unused codes). Each start yields exactly WIDTH_OP handshakes.
- start high in the done cycle (state already IDLE) is accepted at the next edge.
- Reset mid-operation: reset values apply next edge. No done, no further out_valid; the partial scan is abandoned.
- Counter is unsigned DWELL_W bits. No overflow is possible because it only counts down from the latched value.

Decomposition:
- Package mux_pkg: state enum (IDLE, SETTLE, OUTPUT) as 2-bit logic typedef; default WIDTH_IN/WIDTH_OP/WIDTH_BUS/DWELL_W localparams shared with the mux and benches.
- One sub-module: mux_dwell_cnt, a loadable DWELL_W down-counter with load, en and zero flag.
- Bench instantiates mux_scan_ctrl feeding mux_ternar_module with opt = {3'b011,3'b101,3'b100,3'b110} (opt[0]=110 … opt[3]=011).

Test Plan:
- dwell=0, out_ready=1 constant, one start pulse -> handshakes (idx,data) = (0,110),(1,100),(2,101),(3,011). out_valid first high 1 edge after start. done pulses once, one cycle after the 4th handshake.
- dwell=3, out_ready=1 -> out_valid first high 4 edges after start. sel dwells 5 cycles per option (4 SETTLE + 1 OUTPUT); same data sequence.
- Backpressure: out_ready=0 for 5 cycles while idx=1 -> out_data=100, out_idx=1, sel=1 held for all 5 cycles. Scan resumes after ready rises; no data lost or duplicated.
- start pulsed again during SETTLE of idx 2 -> ignored; exactly 4 handshakes and 1 done. Changing dwell mid-scan does not alter timing.
- rst_n=0 for one edge while in OUTPUT at idx 2 -> next cycle out_valid=0, sel=0, busy=0, no done. A fresh start then produces a full 4-option scan from idx 0.
- WIDTH_OP=3 (WIDTH_IN=2) -> data 110,100,101 then done; sel never reaches 3.
